// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

    // Arbiter FSM encoding. The values are fixed so the state stays stable
    // when probed from other tools.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } arb_state_t;

    // Read data returned to a master whose request was abandoned on timeout.
    localparam logic [31:0] ABORT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between m0 (CPU) and m1 (loader/debug).
// Latency: grant is registered; s_mem_valid rises one cycle after a request is seen in IDLE.
// Backpressure: the granted master waits on s_mem_ready; a stuck grant aborts after TIMEOUT_CYCLES.
//
// Ports: clk/reset_n (async active-low); m0_*/m1_* master request/response
// channels; s_* shared memory channel; err_timeout pulses in the abort cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,

    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,

    output logic        err_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_t      state, state_nxt;
    logic            last_grant, last_grant_nxt;
    logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
    logic            rst_done;
    logic            pick;
    logic            cur_master;
    logic            cur_valid;

    // Round-robin pick: on a tie the master that was not served last wins.
    always_comb begin
        pick = 1'b0;
        if (m0_mem_valid && m1_mem_valid) begin
            pick = ~last_grant;
        end else if (m1_mem_valid) begin
            pick = 1'b1;
        end
    end

    assign cur_master = (state == GRANT1);
    assign cur_valid  = cur_master ? m1_mem_valid : m0_mem_valid;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wait_cnt_nxt   = wait_cnt;
        case (state)
            IDLE: begin
                // rst_done blocks arbitration on the first edge after reset release.
                if (rst_done && (m0_mem_valid || m1_mem_valid)) begin
                    state_nxt    = pick ? GRANT1 : GRANT0;
                    wait_cnt_nxt = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (s_mem_ready) begin
                    last_grant_nxt = cur_master;
                    state_nxt      = IDLE;
                end else if (!cur_valid) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    // Recording the owner here lets ABORT steer ready/rdata
                    // from last_grant without a separate owner register.
                    last_grant_nxt = cur_master;
                    state_nxt      = ABORT;
                end else if (wait_cnt != '1) begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            rst_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wait_cnt   <= wait_cnt_nxt;
            rst_done   <= 1'b1;
        end
    end

    // Memory side: pass the owner's request through; zero in IDLE and ABORT.
    always_comb begin
        s_mem_valid = 1'b0;
        s_mem_instr = 1'b0;
        s_mem_addr  = '0;
        s_mem_wdata = '0;
        s_mem_wstrb = '0;
        case (state)
            GRANT0: begin
                s_mem_valid = m0_mem_valid;
                s_mem_instr = m0_mem_instr;
                s_mem_addr  = m0_mem_addr;
                s_mem_wdata = m0_mem_wdata;
                s_mem_wstrb = m0_mem_wstrb;
            end
            GRANT1: begin
                s_mem_valid = m1_mem_valid;
                s_mem_instr = m1_mem_instr;
                s_mem_addr  = m1_mem_addr;
                s_mem_wdata = m1_mem_wdata;
                s_mem_wstrb = m1_mem_wstrb;
            end
            default: ;
        endcase
    end

    assign err_timeout  = (state == ABORT);
    assign m0_mem_ready = ((state == GRANT0) && s_mem_ready) || (err_timeout && !last_grant);
    assign m1_mem_ready = ((state == GRANT1) && s_mem_ready) || (err_timeout && last_grant);
    assign m0_mem_rdata = (err_timeout && !last_grant) ? ABORT_RDATA : s_mem_rdata;
    assign m1_mem_rdata = (err_timeout && last_grant)  ? ABORT_RDATA : s_mem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: number of cycles a granted request may wait for s_mem_ready before the arbiter aborts it.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 m<N>_mem_valid  input  1  master N request, held until m<N>_mem_ready (N=0 CPU, N=1 loader/debug).
REQ-005 m<N>_mem_instr  input  1  master N fetch qualifier.
REQ-006 m<N>_mem_addr  input  32  master N byte address.
REQ-007 m<N>_mem_wdata  input  32  master N write data.
REQ-008 m<N>_mem_wstrb  input  4  master N byte strobes; 4'b0000 = read.
REQ-009 m<N>_mem_ready  output  1  master N transfer complete, one-cycle pulse.
REQ-010 m<N>_mem_rdata  output  32  master N read data, valid while m<N>_mem_ready=1.
REQ-011 s_mem_valid  output  1  request to the shared memory.
REQ-012 s_mem_instr  output  1  forwarded fetch qualifier.
REQ-013 s_mem_addr  output  32  forwarded address.
REQ-014 s_mem_wdata  output  32  forwarded write data.
REQ-015 s_mem_wstrb  output  4  forwarded strobes.
REQ-016 s_mem_ready  input  1  memory completion.
REQ-017 s_mem_rdata  input  32  memory read data.
REQ-018 err_timeout  output  1  one-cycle pulse when a request is aborted by timeout.

Function
REQ-019 The FSM SHALL have states IDLE, GRANT0, GRANT1, ABORT.
REQ-020 In IDLE: only m0 valid -> GRANT0; only m1 valid -> GRANT1; both valid -> master not equal to last_grant wins (round-robin); neither -> stay IDLE.
REQ-021 The grant decision SHALL be registered: s_mem_valid rises one cycle after the winning m<N>_mem_valid is seen in IDLE.
REQ-022 In GRANT<N>: s_mem_valid/instr/addr/wdata/wstrb = master N signals combinationally; all s_* outputs are zero in IDLE and ABORT.
REQ-023 In GRANT<N>: m<N>_mem_ready = s_mem_ready; the other master's ready SHALL be 0.
REQ-024 m0_mem_rdata and m1_mem_rdata SHALL equal s_mem_rdata except in ABORT, where the aborted master sees 32'hDEADBEEF.
REQ-025 On s_mem_ready=1 in GRANT<N>: last_grant <= N, next state IDLE; a new request from either master is arbitrated in IDLE (no back-to-back grant without an IDLE cycle).
REQ-026 If m<N>_mem_valid drops while GRANT<N> and s_mem_ready=0: return to IDLE, no ready to any master, last_grant unchanged.
REQ-027 A wait counter SHALL clear on entry to GRANT<N> and increment each GRANT cycle with s_mem_ready=0; saturating width ceil(log2(TIMEOUT_CYCLES+1)).
REQ-028 When the counter equals TIMEOUT_CYCLES-1 with s_mem_ready=0: next state ABORT.
REQ-029 ABORT lasts one cycle: m<N>_mem_ready=1 for the aborted master, err_timeout=1, last_grant <= N, then IDLE.
REQ-030 s_mem_ready arriving in IDLE or ABORT SHALL be ignored.
REQ-031 reset_n assertion mid-grant SHALL drop s_mem_valid and all readies immediately (asynchronously).

Reset
REQ-032 On reset_n=0: state IDLE, last_grant=1 (m0 wins first tie), counter 0, err_timeout 0, all ready and s_* outputs 0.
REQ-033 Release of reset_n SHALL take effect on the first posedge clk with reset_n=1; no request is granted in that cycle.

Structure
REQ-034 Shared package mem_arb_pkg SHALL hold the arb_state_t enum and the constant ABORT_RDATA = 32'hDEADBEEF.
REQ-035 Single module, no sub-modules; the round-robin pick is an in-module combinational block.

Verification
REQ-036 m0 read addr 0x100, memory ready after 2 cycles with 0x12345678 -> s_mem_valid at cycle 1, m0_mem_ready one pulse with rdata 0x12345678, m1_mem_ready stays 0.
REQ-037 m0 and m1 valid together from reset, each served with 1-cycle memory -> order m0, m1, m0, m1.
REQ-038 m1 write 0x200 data 0xCAFEF00D wstrb 1111 -> s_mem_addr 0x200, s_mem_wdata 0xCAFEF00D, s_mem_wstrb 1111 while GRANT1.
REQ-039 TIMEOUT_CYCLES=4, memory never ready -> after 4 GRANT cycles one ABORT cycle: m0_mem_ready=1, rdata 0xDEADBEEF, err_timeout=1, then IDLE.
REQ-040 reset_n low mid-GRANT0 (asynchronously, between edges) -> s_mem_valid and m0_mem_ready 0 immediately; after release m0 wins the first tie.
